skipjack_stepper: RTL and testbench
===================================

SKIPJACK_STEPPER -- requirements
Module: skipjack_stepper

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have s_axis_tdata  in  64  plaintext block {w1,w2,w3,w4}, w1 in [63:48]; s_axis_tvalid  in  1; s_axis_tready  out  1.
REQ-003 SHALL have m_axis_tdata  out  64  ciphertext block, same word order; m_axis_tvalid  out  1; m_axis_tready  in  1.
REQ-004 SHALL have key  in  80  [0:79] cryptovariable, byte cv0 in [0:7].
REQ-005 SHALL have g_m_axis_tdata  out  16  word sent to G-permutation; g_m_axis_tvalid  out  1; g_m_axis_tready  in  1.
REQ-006 SHALL have g_s_axis_tdata  in  16  G result; g_s_axis_tvalid  in  1; g_s_axis_tready  out  1.
REQ-007 SHALL have g_counter  out  5  current round index 0..31; g_key  out  80  [0:79] latched key to G.

Function
REQ-008 SHALL implement FSM states IDLE, SEND_G, WAIT_G, DONE.
REQ-009 IDLE: s_axis_tready=1; on s_axis_tvalid&&tready latch block into w1..w4, latch key, round:=0, go SEND_G.
REQ-010 SEND_G: g_m_axis_tvalid=1, g_m_axis_tdata=w1; on g_m_axis_tready go WAIT_G.
REQ-011 WAIT_G: g_s_axis_tready=1; on g_s_axis_tvalid apply rule step (REQ-013/014) using G=g_s_axis_tdata.
REQ-012 WAIT_G accept: if round==31 go DONE, else round:=round+1, go SEND_G next cycle.
REQ-013 Rule A (round[3]==0; rounds 0-7, 16-23): w1:=G^w4^k; w2:=G; w3:=w2; w4:=w3.
REQ-014 Rule B (round[3]==1; rounds 8-15, 24-31): w1:=w4; w2:=G; w3:=w1^w2^k (pre-update w1,w2); w4:=w3.
REQ-015 Step value k = round+1 zero-extended to 16 bits (1..32); all XORs mod-2, 16-bit.
REQ-016 g_counter SHALL equal round register; g_key SHALL equal latched key, stable throughout SEND_G/WAIT_G.
REQ-017 DONE: m_axis_tvalid=1, m_axis_tdata={w1,w2,w3,w4}, held stable until m_axis_tready; then IDLE.
REQ-018 Stepper overhead: exactly one cycle (SEND_G) per round beyond G latency when g_m_axis_tready=1; total 32 G transactions per block.
REQ-019 s_axis_tready=0 outside IDLE; new blocks never accepted while busy or in DONE.
REQ-020 g_s_axis_tvalid outside WAIT_G SHALL be ignored; g_m_axis_tvalid=0 outside SEND_G; g_s_axis_tready=0 outside WAIT_G.
REQ-021 Backpressure: g_m_axis_tready low stalls in SEND_G with data stable; m_axis_tready low stalls in DONE indefinitely.
REQ-022 Key input changes after acceptance SHALL NOT affect the in-flight block.

Reset
REQ-023 On rst: state IDLE, w1..w4=0, round=0, latched key=0.
REQ-024 Reset outputs: s_axis_tready=1 after first post-reset cycle; m_axis_tvalid=0, g_m_axis_tvalid=0, g_s_axis_tready=0, m_axis_tdata=0, g_counter=0.
REQ-025 Reset mid-operation SHALL abort the block; no output produced; any G result arriving after reset ignored.

Structure
REQ-026 Package skipjack_pkg SHALL hold: stepper state enum, NUM_ROUNDS=32, WORD_W=16, BLOCK_W=64, KEY_W=80.
REQ-027 Rule A/B word update SHALL be a combinational sub-module rule_step (inputs w1..w4, G, k, rule_b; outputs next w1..w4).
REQ-028 Top-level integration instantiates skipjack_stepper with the G-permutation round block on the g_* ports.

Verification
REQ-029 NIST vector: key=0x00998877665544332211, plaintext=0x33221100ddccbbaa -> m_axis_tdata=0x2587cae27a12d300.
REQ-030 Rule boundaries: monitor g_counter 7->8, 15->16, 23->24; check w-updates against reference model per REQ-013/014.
REQ-031 Backpressure: random g_m_axis_tready/m_axis_tready stalls on NIST vector -> identical ciphertext, data stable while valid&&!ready.
REQ-032 Reset at round 12 -> outputs to reset values, m_axis_tvalid never asserts; next block encrypts correctly.
REQ-033 Back-to-back blocks; key changed after first accept -> first ciphertext uses old key; s_axis_tready=0 until DONE handshake.
REQ-034 Spurious g_s_axis_tvalid pulse in SEND_G and IDLE -> ignored, ciphertext unchanged.

Source files
------------

// File: rtl/skipjack_pkg.sv
// Shared widths, round bookkeeping and FSM encoding for the Skipjack round stepper.
package skipjack_pkg;

   localparam int NUM_ROUNDS = 32;
   localparam int WORD_W     = 16;
   localparam int BLOCK_W    = 64;
   localparam int KEY_W      = 80;
   localparam int ROUND_W    = $clog2(NUM_ROUNDS);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND_G = 2'd1,
      ST_WAIT_G = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Skipjack's counter is one-based while the round register is zero-based.
   function automatic logic [WORD_W-1:0] step_value(input logic [ROUND_W-1:0] round);
      return WORD_W'(round) + WORD_W'(1);
   endfunction

   // Rule B covers rounds 8-15 and 24-31.
   function automatic logic uses_rule_b(input logic [ROUND_W-1:0] round);
      return round[3];
   endfunction

endpackage

// File: rtl/skipjack_stepper_rule_step.sv
// Combinational Skipjack Rule A / Rule B word shuffle for one round.
module rule_step
   import skipjack_pkg::*;
(
   input  logic [WORD_W-1:0] w1,
   input  logic [WORD_W-1:0] w2,
   input  logic [WORD_W-1:0] w3,
   input  logic [WORD_W-1:0] w4,
   input  logic [WORD_W-1:0] g,
   input  logic [WORD_W-1:0] k,
   input  logic              rule_b,
   output logic [WORD_W-1:0] w1_nxt,
   output logic [WORD_W-1:0] w2_nxt,
   output logic [WORD_W-1:0] w3_nxt,
   output logic [WORD_W-1:0] w4_nxt
);

   always_comb begin
      w2_nxt = g;
      w4_nxt = w3;
      if (rule_b) begin
         w1_nxt = w4;
         w3_nxt = w1 ^ w2 ^ k;
      end else begin
         w1_nxt = g ^ w4 ^ k;
         w3_nxt = w2;
      end
   end

endmodule

// File: rtl/skipjack_stepper.sv
// Skipjack encryption round sequencer; the G-permutation lives outside on the g_* streams.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for a plaintext block, s_axis_tready high
//   ST_SEND_G | offering w1 to the G block for the current round
//   ST_WAIT_G | waiting for the G result, then applying Rule A or B
//   ST_DONE   | ciphertext presented on m_axis until accepted
module skipjack_stepper
   import skipjack_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,

   input  logic [BLOCK_W-1:0]   s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,

   output logic [BLOCK_W-1:0]   m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,

   input  logic [0:KEY_W-1]     key,

   output logic [WORD_W-1:0]    g_m_axis_tdata,
   output logic                 g_m_axis_tvalid,
   input  logic                 g_m_axis_tready,

   input  logic [WORD_W-1:0]    g_s_axis_tdata,
   input  logic                 g_s_axis_tvalid,
   output logic                 g_s_axis_tready,

   output logic [ROUND_W-1:0]   g_counter,
   output logic [0:KEY_W-1]     g_key
);

   state_t state, state_nxt;

   logic [WORD_W-1:0]  w1, w2, w3, w4;
   logic [WORD_W-1:0]  w1_nxt, w2_nxt, w3_nxt, w4_nxt;
   logic [ROUND_W-1:0] round;
   logic [0:KEY_W-1]   key_q;

   logic load_block;
   logic g_accept;

   rule_step u_rule_step (
      .w1     (w1),
      .w2     (w2),
      .w3     (w3),
      .w4     (w4),
      .g      (g_s_axis_tdata),
      .k      (step_value(round)),
      .rule_b (uses_rule_b(round)),
      .w1_nxt (w1_nxt),
      .w2_nxt (w2_nxt),
      .w3_nxt (w3_nxt),
      .w4_nxt (w4_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      s_axis_tready   = 1'b0;
      g_m_axis_tvalid = 1'b0;
      g_s_axis_tready = 1'b0;
      m_axis_tvalid   = 1'b0;
      load_block      = 1'b0;
      g_accept        = 1'b0;
      case (state)
         ST_IDLE: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               load_block = 1'b1;
               state_nxt  = ST_SEND_G;
            end
         end
         ST_SEND_G: begin
            g_m_axis_tvalid = 1'b1;
            if (g_m_axis_tready) begin
               state_nxt = ST_WAIT_G;
            end
         end
         ST_WAIT_G: begin
            g_s_axis_tready = 1'b1;
            if (g_s_axis_tvalid) begin
               g_accept  = 1'b1;
               state_nxt = (round == LAST_ROUND) ? ST_DONE : ST_SEND_G;
            end
         end
         ST_DONE: begin
            m_axis_tvalid = 1'b1;
            if (m_axis_tready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Key is captured with the block so later key changes cannot reach an in-flight block.
   always_ff @(posedge clk) begin
      if (rst) begin
         w1    <= '0;
         w2    <= '0;
         w3    <= '0;
         w4    <= '0;
         round <= '0;
         key_q <= '0;
      end else if (load_block) begin
         w1    <= s_axis_tdata[63:48];
         w2    <= s_axis_tdata[47:32];
         w3    <= s_axis_tdata[31:16];
         w4    <= s_axis_tdata[15:0];
         round <= '0;
         key_q <= key;
      end else if (g_accept) begin
         w1 <= w1_nxt;
         w2 <= w2_nxt;
         w3 <= w3_nxt;
         w4 <= w4_nxt;
         if (round != LAST_ROUND) begin
            round <= round + ROUND_W'(1);
         end
      end
   end

   // Intermediate words are masked so the ciphertext port only ever shows finished blocks.
   assign m_axis_tdata   = (state == ST_DONE) ? {w1, w2, w3, w4} : '0;
   assign g_m_axis_tdata = w1;
   assign g_counter      = round;
   assign g_key          = key_q;

endmodule

// File: tb/tb_skipjack_stepper.sv
// Randomized scoreboard bench for skipjack_stepper with a behavioural Skipjack model and G responder.
module tb_skipjack_stepper;

   localparam logic [63:0] NIST_PT  = 64'h33221100ddccbbaa;
   localparam logic [79:0] NIST_KEY = 80'h00998877665544332211;
   localparam logic [63:0] NIST_CT  = 64'h2587cae27a12d300;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [63:0] m_tdata;
   logic        m_valid;
   logic        m_ready;
   logic [0:79] key_in;
   logic [15:0] g_m_tdata;
   logic        g_m_valid;
   logic        g_m_ready;
   logic [15:0] g_s_tdata;
   logic        g_s_valid;
   logic        g_s_ready;
   logic [4:0]  g_counter;
   logic [0:79] g_key_o;

   always #5 clk = ~clk;

   skipjack_stepper dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis_tdata    (s_tdata),
      .s_axis_tvalid   (s_tvalid),
      .s_axis_tready   (s_tready),
      .m_axis_tdata    (m_tdata),
      .m_axis_tvalid   (m_valid),
      .m_axis_tready   (m_ready),
      .key             (key_in),
      .g_m_axis_tdata  (g_m_tdata),
      .g_m_axis_tvalid (g_m_valid),
      .g_m_axis_tready (g_m_ready),
      .g_s_axis_tdata  (g_s_tdata),
      .g_s_axis_tvalid (g_s_valid),
      .g_s_axis_tready (g_s_ready),
      .g_counter       (g_counter),
      .g_key           (g_key_o)
   );

   logic [7:0] ftab [0:255] = '{
      8'ha3,8'hd7,8'h09,8'h83,8'hf8,8'h48,8'hf6,8'hf4,8'hb3,8'h21,8'h15,8'h78,8'h99,8'hb1,8'haf,8'hf9,
      8'he7,8'h2d,8'h4d,8'h8a,8'hce,8'h4c,8'hca,8'h2e,8'h52,8'h95,8'hd9,8'h1e,8'h4e,8'h38,8'h44,8'h28,
      8'h0a,8'hdf,8'h02,8'ha0,8'h17,8'hf1,8'h60,8'h68,8'h12,8'hb7,8'h7a,8'hc3,8'he9,8'hfa,8'h3d,8'h53,
      8'h96,8'h84,8'h6b,8'hba,8'hf2,8'h63,8'h9a,8'h19,8'h7c,8'hae,8'he5,8'hf5,8'hf7,8'h16,8'h6a,8'ha2,
      8'h39,8'hb6,8'h7b,8'h0f,8'hc1,8'h93,8'h81,8'h1b,8'hee,8'hb4,8'h1a,8'hea,8'hd0,8'h91,8'h2f,8'hb8,
      8'h55,8'hb9,8'hda,8'h85,8'h3f,8'h41,8'hbf,8'he0,8'h5a,8'h58,8'h80,8'h5f,8'h66,8'h0b,8'hd8,8'h90,
      8'h35,8'hd5,8'hc0,8'ha7,8'h33,8'h06,8'h65,8'h69,8'h45,8'h00,8'h94,8'h56,8'h6d,8'h98,8'h9b,8'h76,
      8'h97,8'hfc,8'hb2,8'hc2,8'hb0,8'hfe,8'hdb,8'h20,8'he1,8'heb,8'hd6,8'he4,8'hdd,8'h47,8'h4a,8'h1d,
      8'h42,8'hed,8'h9e,8'h6e,8'h49,8'h3c,8'hcd,8'h43,8'h27,8'hd2,8'h07,8'hd4,8'hde,8'hc7,8'h67,8'h18,
      8'h89,8'hcb,8'h30,8'h1f,8'h8d,8'hc6,8'h8f,8'haa,8'hc8,8'h74,8'hdc,8'hc9,8'h5d,8'h5c,8'h31,8'ha4,
      8'h70,8'h88,8'h61,8'h2c,8'h9f,8'h0d,8'h2b,8'h87,8'h50,8'h82,8'h54,8'h64,8'h26,8'h7d,8'h03,8'h40,
      8'h34,8'h4b,8'h1c,8'h73,8'hd1,8'hc4,8'hfd,8'h3b,8'hcc,8'hfb,8'h7f,8'hab,8'he6,8'h3e,8'h5b,8'ha5,
      8'had,8'h04,8'h23,8'h9c,8'h14,8'h51,8'h22,8'hf0,8'h29,8'h79,8'h71,8'h7e,8'hff,8'h8c,8'h0e,8'he2,
      8'h0c,8'hef,8'hbc,8'h72,8'h75,8'h6f,8'h37,8'ha1,8'hec,8'hd3,8'h8e,8'h62,8'h8b,8'h86,8'h10,8'he8,
      8'h08,8'h77,8'h11,8'hbe,8'h92,8'h4f,8'h24,8'hc5,8'h32,8'h36,8'h9d,8'hcf,8'hf3,8'ha6,8'hbb,8'hac,
      8'h5e,8'h6c,8'ha9,8'h13,8'h57,8'h25,8'hb5,8'he3,8'hbd,8'ha8,8'h3a,8'h01,8'h05,8'h59,8'h2a,8'h46
   };

   typedef struct {
      logic [15:0] data;
      logic [4:0]  cnt;
      logic [79:0] kv;
   } gexp_t;

   logic [63:0] exp_q [$];
   gexp_t       gexp_q [$];

   int n_chk  = 0;
   int n_fail = 0;

   bit bp      = 1'b0;
   bit spur_en = 1'b0;
   bit chk_lat = 1'b0;
   int lat_max = 0;

   // handshake observations shared between the monitor and the G responder
   bit          rst_s = 1'b0;
   bit          snd_hs = 1'b0;
   bit          res_hs = 1'b0;
   logic [15:0] snd_data;
   logic [79:0] snd_key;
   logic [4:0]  snd_cnt;
   bit          outstanding = 1'b0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] g_perm(input logic [15:0] w, input int r, input logic [79:0] kv);
      logic [7:0] g [6];
      logic [7:0] cv;
      g[0] = w[15:8];
      g[1] = w[7:0];
      for (int j = 0; j < 4; j++) begin
         cv       = kv[79 - 8 * ((4 * r + j) % 10) -: 8];
         g[j + 2] = ftab[g[j + 1] ^ cv] ^ g[j];
      end
      return {g[4], g[5]};
   endfunction

   // Straight-line Skipjack: records the word offered to G each round, returns the ciphertext.
   task automatic ref_model(input logic [63:0] pt, input logic [79:0] kv, output logic [63:0] ct);
      logic [15:0] w [4];
      logic [15:0] nw [4];
      logic [15:0] g, k;
      gexp_t e;
      w[0] = pt[63:48]; w[1] = pt[47:32]; w[2] = pt[31:16]; w[3] = pt[15:0];
      for (int r = 0; r < 32; r++) begin
         e.data = w[0]; e.cnt = 5'(r); e.kv = kv;
         gexp_q.push_back(e);
         g = g_perm(w[0], r, kv);
         k = 16'(r + 1);
         if (((r / 8) % 2) == 0) begin
            nw[0] = g ^ w[3] ^ k; nw[1] = g; nw[2] = w[1]; nw[3] = w[2];
         end else begin
            nw[0] = w[3]; nw[1] = g; nw[2] = w[0] ^ w[1] ^ k; nw[3] = w[2];
         end
         w = nw;
      end
      ct = {w[0], w[1], w[2], w[3]};
   endtask

   // ready generators
   initial begin
      g_m_ready = 1'b1;
      m_ready   = 1'b1;
      forever begin
         @(posedge clk); #1;
         g_m_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         m_ready   = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      end
   end

   // external G block stand-in, plus stale results after reset and spurious pulses
   initial begin
      bit          busy = 1'b0;
      bit          spur_on = 1'b0;
      int          lat = 0;
      int          stale = 0;
      logic [15:0] pend = '0;
      g_s_valid = 1'b0;
      g_s_tdata = '0;
      forever begin
         @(posedge clk); #1;
         if (spur_on) begin g_s_valid = 1'b0; spur_on = 1'b0; end
         if (rst_s) begin
            busy = 1'b0;
            if (g_s_valid) stale = 3;
         end else if (res_hs) begin
            g_s_valid = 1'b0;
            busy = 1'b0;
         end
         if (stale > 0) begin
            stale--;
            if (stale == 0) g_s_valid = 1'b0;
         end
         if (snd_hs && !rst_s) begin
            busy = 1'b1;
            pend = g_perm(snd_data, int'(snd_cnt), snd_key);
            lat  = $urandom_range(0, lat_max);
         end
         if (busy && !g_s_valid) begin
            if (lat == 0) begin g_s_valid = 1'b1; g_s_tdata = pend; end
            else lat--;
         end else if (!busy && stale == 0 && spur_en && $urandom_range(0, 3) == 0) begin
            g_s_valid = 1'b1;
            g_s_tdata = 16'($urandom);
            spur_on   = 1'b1;
         end
      end
   end

   // monitor: pops scoreboard queues whenever the DUT presents a transfer
   initial begin
      bit          prev_gm_stall = 1'b0;
      bit          prev_m_stall = 1'b0;
      bit          prev_m_valid = 1'b0;
      logic [15:0] prev_gm_data = '0;
      logic [63:0] prev_m_data = '0;
      logic [63:0] expv;
      int          sends = 0;
      int          cyc = 0;
      gexp_t       e;
      forever begin
         @(negedge clk);
         rst_s  = rst;
         snd_hs = 1'b0;
         res_hs = 1'b0;
         if (rst) begin
            outstanding   = 1'b0;
            sends         = 0;
            prev_gm_stall = 1'b0;
            prev_m_stall  = 1'b0;
            prev_m_valid  = 1'b0;
         end else begin
            if (prev_gm_stall) begin
               check("g_m_hold_valid", g_m_valid, 1);
               check("g_m_hold_data", g_m_tdata, prev_gm_data);
            end
            if (prev_m_stall) begin
               check("m_hold_valid", m_valid, 1);
               check("m_hold_data", m_tdata, prev_m_data);
            end
            if (g_m_valid) check("g_s_ready_in_send", g_s_ready, 0);
            if (g_m_valid && g_m_ready) begin
               snd_hs   = 1'b1;
               snd_data = g_m_tdata;
               snd_cnt  = g_counter;
               snd_key  = g_key_o;
               sends++;
               if (gexp_q.size() == 0) check("g_send_unexpected", g_m_valid, 0);
               else begin
                  e = gexp_q.pop_front();
                  check("g_word", g_m_tdata, e.data);
                  check("g_counter", g_counter, e.cnt);
                  check("g_key", snd_key, e.kv);
               end
            end
            res_hs = g_s_valid && g_s_ready;
            if (outstanding && !m_valid) cyc++;
            if (m_valid) begin
               if (!prev_m_valid && chk_lat) check("block_latency", cyc, 64);
               if (exp_q.size() == 0) check("unexpected_m_valid", m_valid, 0);
               else if (m_ready) begin
                  expv = exp_q.pop_front();
                  check("ciphertext", m_tdata, expv);
                  check("g_transactions", sends, 32);
                  sends       = 0;
                  outstanding = 1'b0;
               end
            end
            if (outstanding) check("s_ready_busy", s_tready, 0);
            if (s_tvalid && s_tready) begin
               outstanding = 1'b1;
               cyc   = 0;
               sends = 0;
            end
            prev_gm_stall = g_m_valid && !g_m_ready;
            prev_gm_data  = g_m_tdata;
            prev_m_stall  = m_valid && !m_ready;
            prev_m_data   = m_tdata;
            prev_m_valid  = m_valid;
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_s_tready"}, s_tready, 1);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_g_m_valid"}, g_m_valid, 0);
      check({tag, "_g_s_ready"}, g_s_ready, 0);
      check({tag, "_m_tdata"}, m_tdata, 0);
      check({tag, "_g_counter"}, g_counter, 0);
   endtask

   task automatic send_block(input logic [63:0] pt, input logic [79:0] kv, input bit nist);
      logic [63:0] ct;
      int n = 0;
      @(posedge clk); #1;
      s_tdata  = pt;
      s_tvalid = 1'b1;
      key_in   = kv;
      @(negedge clk);
      while (!s_tready && n < 4000) begin @(negedge clk); n++; end
      if (!s_tready) begin
         check("accept_wait", s_tready, 1);
         @(posedge clk); #1;
         s_tvalid = 1'b0;
         return;
      end
      ref_model(pt, kv, ct);
      exp_q.push_back(nist ? NIST_CT : ct);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tdata  = {$urandom(), $urandom()};
      key_in   = 80'({$urandom(), $urandom(), $urandom()});
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || outstanding) && n < 8000) begin @(negedge clk); n++; end
      check("drain", 32'(exp_q.size()), 0);
      exp_q.delete();
      gexp_q.delete();
   endtask

   function automatic logic [79:0] rand_key();
      return 80'({$urandom(), $urandom(), $urandom()});
   endfunction

   initial begin
      int n;
      rst      = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      key_in   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("reset");

      // nominal NIST vector, no stalls: also checks one SEND cycle per round
      chk_lat = 1'b1;
      send_block(NIST_PT, NIST_KEY, 1'b1);
      wait_drain();
      chk_lat = 1'b0;

      lat_max = 3;
      for (int i = 0; i < 3; i++) begin
         send_block({$urandom(), $urandom()}, rand_key(), 1'b0);
         wait_drain();
      end

      bp = 1'b1;
      send_block(NIST_PT, NIST_KEY, 1'b1);
      wait_drain();
      bp = 1'b0;

      // abort at round 12
      send_block({$urandom(), $urandom()}, rand_key(), 1'b0);
      n = 0;
      while (g_counter != 5'd12 && n < 2000) begin @(negedge clk); n++; end
      check("reach_round12", g_counter, 12);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      gexp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset("abort");
      repeat (20) @(negedge clk);
      send_block(NIST_PT, NIST_KEY, 1'b1);
      wait_drain();

      // back-to-back with key scrambled after each accept
      send_block({$urandom(), $urandom()}, rand_key(), 1'b0);
      send_block(NIST_PT, NIST_KEY, 1'b1);
      send_block({$urandom(), $urandom()}, rand_key(), 1'b0);
      wait_drain();

      spur_en = 1'b1;
      send_block(NIST_PT, NIST_KEY, 1'b1);
      wait_drain();

      for (int i = 0; i < 16; i++) begin
         bp      = ($urandom_range(0, 1) == 1);
         lat_max = $urandom_range(0, 3);
         spur_en = ($urandom_range(0, 1) == 1);
         send_block({$urandom(), $urandom()}, rand_key(), 1'b0);
         if (i % 4 == 3) wait_drain();
      end
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
